// File: rtl/regfile_sb_pkg.sv
// ---------------------------------------------------------------------------
// regfile_sb_pkg
// Shared constants for the scoreboarded register file:
//   XLEN_DEF  - default data width in bits
//   NREGS_DEF - default number of architectural registers
//   ZERO_REG  - index of the hard-wired zero register
// ---------------------------------------------------------------------------
package regfile_sb_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int ZERO_REG  = 0;

endpackage : regfile_sb_pkg

// File: rtl/regfile_sb_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_sb_scoreboard
// Tracks which registers have a write outstanding and decides whether an
// issuing instruction has to be held back.
//
// Build option: REGFILE_SB_BYPASS_EN -- when defined, a writeback in the
// current cycle masks the busy bit seen by the source operands.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   rs1_addr_i, rs2_addr_i      source register addresses
//   issue_valid_i, issue_rd_i   issuing instruction and its destination
//   wb_valid_i, wb_rd_i         writeback in this cycle
//   rs1_busy_o, rs2_busy_o      effective busy of each source
//   issue_stall_o               issue refused this cycle
//   pending_cnt_o               number of set busy bits (registered)
// ---------------------------------------------------------------------------
module regfile_sb_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rs1_addr_i,
    input  logic [AW-1:0] rs2_addr_i,
    input  logic          issue_valid_i,
    input  logic [AW-1:0] issue_rd_i,
    input  logic          wb_valid_i,
    input  logic [AW-1:0] wb_rd_i,
    output logic          rs1_busy_o,
    output logic          rs2_busy_o,
    output logic          issue_stall_o,
    output logic [AW:0]   pending_cnt_o
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;

    logic rs1_busy_s;
    logic rs2_busy_s;
    logic waw_s;
    logic stall_s;
    logic set_s;
    logic clr_s;

    // Effective source busy, WAW hazard and issue stall.
    always_comb begin
`ifdef REGFILE_SB_BYPASS_EN
        // The writeback lands in this cycle and is forwarded, so the
        // source is already usable.
        rs1_busy_s = busy_q[rs1_addr_i] && !(wb_valid_i && (wb_rd_i == rs1_addr_i));
        rs2_busy_s = busy_q[rs2_addr_i] && !(wb_valid_i && (wb_rd_i == rs2_addr_i));
`else
        rs1_busy_s = busy_q[rs1_addr_i];
        rs2_busy_s = busy_q[rs2_addr_i];
`endif
        // A pending write to the destination that retires this cycle is
        // no longer a hazard: the new issue's busy bit replaces it.
        waw_s   = busy_q[issue_rd_i] && !(wb_valid_i && (wb_rd_i == issue_rd_i));
        stall_s = issue_valid_i && (rs1_busy_s || rs2_busy_s || waw_s);
    end

    // Busy vector and pending counter next state.
    always_comb begin
        set_s  = issue_valid_i && !stall_s && (issue_rd_i != ZERO_ADDR);
        // Only a writeback that really retires a busy bit decrements the
        // count; writebacks to idle registers are legal and leave it alone.
        clr_s  = wb_valid_i && (wb_rd_i != ZERO_ADDR) && busy_q[wb_rd_i];
        busy_d = busy_q;
        if (clr_s) begin
            busy_d[wb_rd_i] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        // Applied after the clear so a same-register issue wins.
        if (set_s) begin
            busy_d[issue_rd_i] = 1'b1;
        end else begin
            busy_d[issue_rd_i] = busy_d[issue_rd_i];
        end
        case ({set_s, clr_s})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Busy vector and pending counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign rs1_busy_o    = rs1_busy_s;
    assign rs2_busy_o    = rs2_busy_s;
    assign issue_stall_o = stall_s;
    assign pending_cnt_o = cnt_q;

endmodule : regfile_sb_scoreboard

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Two-read, one-write register file with a busy-bit scoreboard. Register 0
// reads as zero and is never written or marked busy.
//
// Build option: REGFILE_SB_BYPASS_EN -- when defined, a writeback is
// forwarded to the read ports in the same cycle; otherwise the new value is
// visible from the next cycle.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   rs1_addr, rs2_addr              read addresses
//   rs1_data, rs2_data              combinational read data
//   rs1_busy, rs2_busy              source has a pending write
//   issue_valid, issue_rd           issuing instruction and destination
//   issue_stall                     issue refused this cycle
//   wb_valid, wb_rd, wb_data        writeback
//   pending_cnt                     number of set busy bits
// ---------------------------------------------------------------------------
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int  XLEN  = XLEN_DEF,
    parameter int  NREGS = NREGS_DEF,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            issue_valid,
    input  logic [AW-1:0]   issue_rd,
    output logic            issue_stall,
    input  logic            wb_valid,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [AW:0]     pending_cnt
);

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    // Array next state: one write port, register 0 never written.
    always_comb begin
        regs_d = regs_q;
        if (wb_valid && (wb_rd != ZERO_ADDR)) begin
            regs_d[wb_rd] = wb_data;
        end else begin
            regs_d = regs_q;
        end
    end

    // Array storage, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read ports: zero register, optional forwarding, then the array.
    // Outputs are forced to zero while reset is held so a writeback on the
    // bus cannot leak through the forwarding path.
    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (!rst_n || (rs1_addr == ZERO_ADDR)) begin
            rs1_data = '0;
`ifdef REGFILE_SB_BYPASS_EN
        end else if (wb_valid && (wb_rd == rs1_addr)) begin
            rs1_data = wb_data;
`endif
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
        if (!rst_n || (rs2_addr == ZERO_ADDR)) begin
            rs2_data = '0;
`ifdef REGFILE_SB_BYPASS_EN
        end else if (wb_valid && (wb_rd == rs2_addr)) begin
            rs2_data = wb_data;
`endif
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
    end

    regfile_sb_scoreboard #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs1_addr_i    (rs1_addr),
        .rs2_addr_i    (rs2_addr),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .wb_valid_i    (wb_valid),
        .wb_rd_i       (wb_rd),
        .rs1_busy_o    (rs1_busy),
        .rs2_busy_o    (rs2_busy),
        .issue_stall_o (issue_stall),
        .pending_cnt_o (pending_cnt)
    );

endmodule : regfile_sb
